// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit peripheral: register map,
// STAT bit positions and serializer state encoding.
package uart_pkg;

  // Word offsets on the 2-bit request address
  localparam logic [1:0] UART_STAT_OFF = 2'd0;
  localparam logic [1:0] UART_RX_OFF   = 2'd1;
  localparam logic [1:0] UART_TX_OFF   = 2'd2;

  // STAT register bits
  localparam logic [3:0] UART_RXEMPTY = 4'b0001;
  localparam logic [3:0] UART_RXFULL  = 4'b0010;
  localparam logic [3:0] UART_TXEMPTY = 4'b0100;
  localparam logic [3:0] UART_TXFULL  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Head entry is presented combinationally on rdata.
// Push at full and pop at empty are ignored; fullness is judged on the
// count held at the start of the cycle, so a push at full is dropped even
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter: STAT/RX/TX register decode, one-cycle
// read response, TX FIFO and an 8N1 LSB-first serializer on txd.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_addr,
  input  logic [3:0]  req_wmask,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        txd
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        resp_valid_q, resp_is_stat_q;

  logic        tx_push, tx_pop;
  logic [7:0]  fifo_rdata;
  logic        fifo_full, fifo_empty;
  logic        tx_empty;
  logic [3:0]  stat_bits;

  // Only the low byte of a TX write carries data
  logic unused_bits;
  assign unused_bits = ^{req_wdata[31:8], req_wmask[3:1]};

  assign tx_push = req_valid & req_write & (req_addr == UART_TX_OFF) & req_wmask[0];

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (req_wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx_empty  = fifo_empty & (state_q == IDLE);
  assign stat_bits = (fifo_full ? UART_TXFULL  : 4'b0000)
                   | (tx_empty  ? UART_TXEMPTY : 4'b0000)
                   | UART_RXEMPTY;

  // Only the read's validity and target are registered; STAT is muxed from
  // live status in the response cycle so it already reflects any push/pop
  // made in the request cycle.
  assign resp_valid = resp_valid_q;
  assign resp_rdata = (resp_valid_q && resp_is_stat_q) ? {28'b0, stat_bits} : '0;

  // Read-response register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid_q   <= 1'b0;
      resp_is_stat_q <= 1'b0;
    end else begin
      resp_valid_q   <= req_valid & ~req_write;
      resp_is_stat_q <= (req_addr == UART_STAT_OFF);
    end
  end

  // Serializer next-state, FIFO pop and line output
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_pop    = 1'b0;
    txd       = 1'b1;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          tx_pop  = 1'b1;
          shift_d = fifo_rdata;
          baud_d  = BAUD_MAX;
          state_d = START;
        end
      end
      START: begin
        txd = 1'b0;
        if (baud_q == '0) begin
          baud_d    = BAUD_MAX;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      DATA: begin
        txd = shift_q[0];
        if (baud_q == '0) begin
          baud_d  = BAUD_MAX;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      STOP: begin
        txd = 1'b1;
        if (baud_q == '0) begin
          if (!fifo_empty) begin
            tx_pop  = 1'b1;
            shift_d = fifo_rdata;
            baud_d  = BAUD_MAX;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serializer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4. The reference model
// is a schedule of frames: each accepted byte gets a start cycle, from which
// the expected line level and STAT are computed arithmetically.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_addr = '0;
  logic [3:0]  req_wmask = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        txd;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  bit mon_en = 1'b0;
  int txd_prints = 0;

  // Model: per accepted byte, its write cycle, frame start cycle and value
  int         wcyc_q[$];
  int         start_q[$];
  logic [7:0] data_q[$];

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wmask  (req_wmask),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .txd        (txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bytes held in the FIFO during cycle c: written before c, popped at or after c
  function automatic int fifo_count(int c);
    int n = 0;
    foreach (start_q[i]) if (wcyc_q[i] < c && c <= start_q[i] - 1) n++;
    return n;
  endfunction

  function automatic bit frame_active(int c);
    foreach (start_q[i]) if (c >= start_q[i] && c < start_q[i] + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_stat(int c);
    int n = fifo_count(c);
    return {28'b0, (n == DEPTH), (n == 0 && !frame_active(c)), 1'b0, 1'b1};
  endfunction

  function automatic logic exp_txd(int c);
    foreach (start_q[i]) begin
      if (c >= start_q[i] && c < start_q[i] + FRAME) begin
        int k = (c - start_q[i]) / CPB;
        logic [7:0] b = data_q[i];
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic void model_write(int c, logic [7:0] b);
    int s;
    if (fifo_count(c) == DEPTH) return;
    s = c + 2;
    if (start_q.size() > 0 && start_q[$] + FRAME > s) s = start_q[$] + FRAME;
    wcyc_q.push_back(c);
    start_q.push_back(s);
    data_q.push_back(b);
  endfunction

  function automatic void model_clear();
    wcyc_q.delete();
    start_q.delete();
    data_q.delete();
  endfunction

  // Line scoreboard: every cycle txd must match the frame schedule
  always @(negedge clk) begin
    if (mon_en) begin
      logic e;
      e = exp_txd(cyc);
      n_total++;
      if (txd === e) n_pass++;
      else begin
        if (txd_prints < 20) $display("FAIL txd cycle %0d: got %b expected %b", cyc, txd, e);
        txd_prints++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [3:0] m, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    req_wmask = m;
    req_wdata = d;
    if (a == 2'd2 && m[0]) model_write(cyc, d[7:0]);
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  // Issues a read, samples the response one cycle later, returns model expectation
  task automatic bus_read(input logic [1:0] a, output logic v, output logic [31:0] d,
                          output logic [31:0] e);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
    #3;
    v = resp_valid;
    d = resp_rdata;
    e = (a == 2'd0) ? exp_stat(cyc) : 32'h0;
    tick();
  endtask

  task automatic test_reset();
    logic v;
    logic [31:0] d, e;
    mon_en = 1'b0;
    rst_n = 1'b0;
    idle(2);
    #3;
    n_total++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b expected 1", txd); else n_pass++;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); else n_pass++;
    n_total++; if (resp_rdata !== 32'h0) $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); else n_pass++;
    tick();
    rst_n = 1'b1;
    model_clear();
    mon_en = 1'b1;
    bus_read(2'd0, v, d, e);
    n_total++; if (v !== 1'b1) $display("FAIL idle_stat_valid: got %b expected 1", v); else n_pass++;
    n_total++; if (d !== 32'h5) $display("FAIL idle_stat: got %h expected 5", d); else n_pass++;
    #3;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL resp_valid_one_cycle: got %b expected 0", resp_valid); else n_pass++;
    tick();
  endtask

  task automatic test_single_frame();
    logic v;
    logic [31:0] d, e;
    bus_write(2'd2, 4'hF, 32'hA5);
    #3;
    n_total++; if (txd !== 1'b1) $display("FAIL single_pop_cycle_txd: got %b expected 1", txd); else n_pass++;
    tick();
    #3;
    n_total++; if (txd !== 1'b0) $display("FAIL single_start_edge: got %b expected 0", txd); else n_pass++;
    tick();
    bus_read(2'd0, v, d, e);
    n_total++; if (v !== 1'b1 || d !== 32'h1) $display("FAIL single_busy_stat: got %b/%h expected 1/1", v, d); else n_pass++;
    idle(40);
    bus_read(2'd0, v, d, e);
    n_total++; if (d !== 32'h5) $display("FAIL single_done_stat: got %h expected 5", d); else n_pass++;
  endtask

  task automatic test_overflow();
    logic v;
    logic [31:0] d, e;
    for (int i = 0; i < 6; i++) bus_write(2'd2, 4'hF, 32'h41 + i);
    bus_read(2'd0, v, d, e);
    n_total++; if (d !== 32'h9) $display("FAIL overflow_full_stat: got %h expected 9", d); else n_pass++;
    idle(200);
    bus_read(2'd0, v, d, e);
    n_total++; if (d !== 32'h5) $display("FAIL overflow_drain_stat: got %h expected 5", d); else n_pass++;
  endtask

  task automatic test_ignored_writes();
    logic v;
    logic [31:0] d, e;
    bus_write(2'd2, 4'b1110, 32'h77);
    bus_write(2'd0, 4'hF, 32'hFF);
    bus_write(2'd1, 4'hF, 32'h55);
    bus_write(2'd3, 4'hF, 32'h66);
    idle(2);
    bus_read(2'd1, v, d, e);
    n_total++; if (v !== 1'b1 || d !== 32'h0) $display("FAIL rx_read: got %b/%h expected 1/0", v, d); else n_pass++;
    bus_read(2'd3, v, d, e);
    n_total++; if (v !== 1'b1 || d !== 32'h0) $display("FAIL reserved_read: got %b/%h expected 1/0", v, d); else n_pass++;
    bus_read(2'd0, v, d, e);
    n_total++; if (d !== 32'h5) $display("FAIL ignored_stat: got %h expected 5", d); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic v;
    logic [31:0] d, e;
    bus_write(2'd2, 4'hF, 32'h11);
    bus_write(2'd2, 4'hF, 32'h22);
    bus_write(2'd2, 4'hF, 32'h33);
    idle(16);
    rst_n = 1'b0;
    tick();
    model_clear();
    rst_n = 1'b1;
    #3;
    n_total++; if (txd !== 1'b1) $display("FAIL midframe_reset_txd: got %b expected 1", txd); else n_pass++;
    tick();
    idle(60);
    bus_read(2'd0, v, d, e);
    n_total++; if (d !== 32'h5) $display("FAIL midframe_reset_stat: got %h expected 5", d); else n_pass++;
  endtask

  task automatic test_full_boundary();
    logic v;
    logic [31:0] d, e;
    for (int i = 0; i < 5; i++) bus_write(2'd2, 4'hF, 32'hC1 + i);
    idle(36);
    bus_write(2'd2, 4'hF, 32'hD1);
    bus_write(2'd2, 4'hF, 32'hD2);
    bus_read(2'd0, v, d, e);
    n_total++; if (d !== 32'h9) $display("FAIL boundary_refill_stat: got %h expected 9", d); else n_pass++;
    idle(200);
    bus_read(2'd0, v, d, e);
    n_total++; if (d !== 32'h5) $display("FAIL boundary_drain_stat: got %h expected 5", d); else n_pass++;
  endtask

  task automatic test_random();
    logic v;
    logic [31:0] d, e;
    int r;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        bus_write(2'd2, {3'($urandom), 1'b1}, $urandom);
      end else if (r < 62) begin
        bus_write(2'd2, {3'($urandom), 1'b0}, $urandom);
      end else if (r < 70) begin
        bus_write(2'($urandom_range(0, 1) * 3), 4'($urandom), $urandom);
      end else if (r < 88) begin
        bus_read(2'd0, v, d, e);
        n_total++;
        if (v !== 1'b1 || d !== e) $display("FAIL random_stat @%0d: got %b/%h expected 1/%h", cyc, v, d, e);
        else n_pass++;
      end else begin
        idle($urandom_range(1, 80));
      end
    end
    idle((DEPTH + 1) * FRAME + 10);
    bus_read(2'd0, v, d, e);
    n_total++; if (d !== 32'h5) $display("FAIL random_drain_stat: got %h expected 5", d); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_ignored_writes();
    test_reset_mid_frame();
    test_full_boundary();
    test_random();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
